// File: rtl/sb_input_pkg.sv
// Shared constants for the Super Bagman input stage: PS/2 key codes, joystick
// bit positions, player control vector layout and the coin FSM state type.
package sb_input_pkg;

  localparam int NUM_PLAYERS = 2;
  localparam int CTRL_W      = 6;

  // {extended, scan code}
  localparam logic [8:0] KC_P1_UP     = 9'h175;
  localparam logic [8:0] KC_P1_DOWN   = 9'h172;
  localparam logic [8:0] KC_P1_LEFT   = 9'h16B;
  localparam logic [8:0] KC_P1_RIGHT  = 9'h174;
  localparam logic [8:0] KC_P1_FIRE1  = 9'h029;
  localparam logic [8:0] KC_P1_FIRE2  = 9'h014;
  localparam logic [8:0] KC_START1_A  = 9'h016;
  localparam logic [8:0] KC_START1_B  = 9'h005;
  localparam logic [8:0] KC_START2_A  = 9'h01E;
  localparam logic [8:0] KC_START2_B  = 9'h006;
  localparam logic [8:0] KC_COIN_A    = 9'h02E;
  localparam logic [8:0] KC_COIN_B    = 9'h036;
  localparam logic [8:0] KC_TEST      = 9'h02C;
  localparam logic [8:0] KC_P2_UP     = 9'h02D;
  localparam logic [8:0] KC_P2_DOWN   = 9'h02B;
  localparam logic [8:0] KC_P2_LEFT   = 9'h023;
  localparam logic [8:0] KC_P2_RIGHT  = 9'h034;
  localparam logic [8:0] KC_P2_FIRE1  = 9'h01C;
  localparam logic [8:0] KC_P2_FIRE2  = 9'h01A;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE1  = 4;
  localparam int JOY_FIRE2  = 5;
  localparam int JOY_START1 = 6;
  localparam int JOY_START2 = 7;
  localparam int JOY_COIN   = 8;

  // Control vector shares the low six joystick bit positions.
  localparam int CTRL_RIGHT = 0;
  localparam int CTRL_LEFT  = 1;
  localparam int CTRL_DOWN  = 2;
  localparam int CTRL_UP    = 3;
  localparam int CTRL_FIRE1 = 4;
  localparam int CTRL_FIRE2 = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } coin_state_t;

endpackage

// File: rtl/sb_coin_shaper.sv
// Turns a raw coin level into one fixed-length pulse of COIN_FRAMES frame ticks,
// then locks out until the coin line is released.
module sb_coin_shaper
  import sb_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int CNT_W       = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic coin
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COIN_FRAMES - 1);

  coin_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw_q, coin_q, coin_d;
  logic             rise;

  assign rise = raw & ~raw_q;
  assign coin = coin_q;

  // Edge history resets high so a coin held through reset is not an event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      raw_q   <= 1'b1;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw;
      coin_q  <= coin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PULSE;
          cnt_d   = '0;
        end
      end
      PULSE: begin
        if (tick) begin
          if (cnt_q == LAST) state_d = WAIT_REL;
          else               cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!raw) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered from the next state so the pulse starts one cycle after the edge.
  always_comb begin
    coin_d = (state_d == PULSE);
  end

endmodule

// File: rtl/sb_input_ctrl.sv
// Super Bagman input conditioning: PS/2 key decode merged with two joystick
// words into registered controls, plus shaped coin. Optional autofire on fire1
// is built when SB_AUTOFIRE_EN is defined.
module sb_input_ctrl
  import sb_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int CNT_W       = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        vblank,
`ifdef SB_AUTOFIRE_EN
  input  logic        autofire,
`endif
  output logic [5:0]  p1_ctrl,
  output logic [5:0]  p2_ctrl,
  output logic        start1,
  output logic        start2,
  output logic        coin,
  output logic        test
);

  logic [NUM_PLAYERS-1:0][15:0]       joy;
  logic [NUM_PLAYERS-1:0][CTRL_W-1:0] pl_key_q, pl_key_d;
  logic [NUM_PLAYERS-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [1:0] start_key_q, start_key_d;
  logic [1:0] coin_key_q, coin_key_d;
  logic       test_key_q, test_key_d;
  logic [1:0] start_q, start_d;
  logic       test_q, test_d;
  logic       tog_q, tog_d;
  logic       vblank_q, vblank_d;
  logic       key_evt, tick, coin_raw;
  logic [8:0] code;
  logic       unused_ok;

  assign joy      = {joystick_1, joystick_0};
  assign code     = ps2_key[8:0];
  assign key_evt  = ps2_key[10] ^ tog_q;
  assign tick     = vblank & ~vblank_q;
  assign tog_d    = ps2_key[10];
  assign vblank_d = vblank;
  assign coin_raw = |coin_key_q | joystick_0[JOY_COIN] | joystick_1[JOY_COIN];
  assign unused_ok = ^{joystick_0[15:9], joystick_1[15:9]};

  always_comb begin
    pl_key_d    = pl_key_q;
    start_key_d = start_key_q;
    coin_key_d  = coin_key_q;
    test_key_d  = test_key_q;
    if (key_evt) begin
      case (code)
        KC_P1_UP:    pl_key_d[0][CTRL_UP]    = ps2_key[9];
        KC_P1_DOWN:  pl_key_d[0][CTRL_DOWN]  = ps2_key[9];
        KC_P1_LEFT:  pl_key_d[0][CTRL_LEFT]  = ps2_key[9];
        KC_P1_RIGHT: pl_key_d[0][CTRL_RIGHT] = ps2_key[9];
        KC_P1_FIRE1: pl_key_d[0][CTRL_FIRE1] = ps2_key[9];
        KC_P1_FIRE2: pl_key_d[0][CTRL_FIRE2] = ps2_key[9];
        KC_P2_UP:    pl_key_d[1][CTRL_UP]    = ps2_key[9];
        KC_P2_DOWN:  pl_key_d[1][CTRL_DOWN]  = ps2_key[9];
        KC_P2_LEFT:  pl_key_d[1][CTRL_LEFT]  = ps2_key[9];
        KC_P2_RIGHT: pl_key_d[1][CTRL_RIGHT] = ps2_key[9];
        KC_P2_FIRE1: pl_key_d[1][CTRL_FIRE1] = ps2_key[9];
        KC_P2_FIRE2: pl_key_d[1][CTRL_FIRE2] = ps2_key[9];
        KC_START1_A, KC_START1_B: start_key_d[0] = ps2_key[9];
        KC_START2_A, KC_START2_B: start_key_d[1] = ps2_key[9];
        KC_COIN_A:   coin_key_d[0] = ps2_key[9];
        KC_COIN_B:   coin_key_d[1] = ps2_key[9];
        KC_TEST:     test_key_d    = ps2_key[9];
        default: ;
      endcase
    end
  end

`ifdef SB_AUTOFIRE_EN
  // Phase 0 means the fire1 output is high; each tick while held flips it.
  logic [NUM_PLAYERS-1:0] ph_q, ph_d;
`endif

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      ctrl_d[p] = pl_key_q[p] | joy[p][CTRL_W-1:0];
`ifdef SB_AUTOFIRE_EN
      ph_d[p] = ctrl_d[p][CTRL_FIRE1] ? (ph_q[p] ^ tick) : 1'b0;
      if (autofire) ctrl_d[p][CTRL_FIRE1] = ctrl_d[p][CTRL_FIRE1] & ~ph_d[p];
`endif
    end
    start_d[0] = start_key_q[0] | joystick_0[JOY_START1] | joystick_1[JOY_START1];
    start_d[1] = start_key_q[1] | joystick_0[JOY_START2] | joystick_1[JOY_START2];
    test_d     = test_key_q;
  end

  // Toggle history reloads the live bit so leaving reset is never an event.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q       <= ps2_key[10];
      vblank_q    <= 1'b0;
      pl_key_q    <= '0;
      start_key_q <= '0;
      coin_key_q  <= '0;
      test_key_q  <= 1'b0;
      ctrl_q      <= '0;
      start_q     <= '0;
      test_q      <= 1'b0;
`ifdef SB_AUTOFIRE_EN
      ph_q        <= '0;
`endif
    end else begin
      tog_q       <= tog_d;
      vblank_q    <= vblank_d;
      pl_key_q    <= pl_key_d;
      start_key_q <= start_key_d;
      coin_key_q  <= coin_key_d;
      test_key_q  <= test_key_d;
      ctrl_q      <= ctrl_d;
      start_q     <= start_d;
      test_q      <= test_d;
`ifdef SB_AUTOFIRE_EN
      ph_q        <= ph_d;
`endif
    end
  end

  assign p1_ctrl = ctrl_q[0];
  assign p2_ctrl = ctrl_q[1];
  assign start1  = start_q[0];
  assign start2  = start_q[1];
  assign test    = test_q;

  sb_coin_shaper #(
    .COIN_FRAMES (COIN_FRAMES),
    .CNT_W       (CNT_W)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (coin_raw),
    .tick    (tick),
    .coin    (coin)
  );

endmodule

// File: tb/tb_sb_input_ctrl.sv
// Directed bench for sb_input_ctrl: reset behaviour, key/joystick paths,
// coin shaping and retrigger lockout, autofire when SB_AUTOFIRE_EN is set.
module tb_sb_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        vblank;
  logic [5:0]  p1_ctrl, p2_ctrl;
  logic        start1, start2, coin, test;
`ifdef SB_AUTOFIRE_EN
  logic        autofire;
`endif

  int n_run = 0, n_fail = 0;
  int coin_hi = 0, coin_rise = 0;
  logic coin_prev = 1'b0;

  always #5 clk_sys = ~clk_sys;

  sb_input_ctrl #(.COIN_FRAMES(3), .CNT_W(4)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .vblank     (vblank),
`ifdef SB_AUTOFIRE_EN
    .autofire   (autofire),
`endif
    .p1_ctrl    (p1_ctrl),
    .p2_ctrl    (p2_ctrl),
    .start1     (start1),
    .start2     (start2),
    .coin       (coin),
    .test       (test)
  );

  always @(posedge clk_sys) begin
    if (coin) coin_hi <= coin_hi + 1;
    if (coin && !coin_prev) coin_rise <= coin_rise + 1;
    coin_prev <= coin;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic key(input logic pressed, input logic ext, input logic [7:0] sc);
    ps2_key = {~ps2_key[10], pressed, ext, sc};
  endtask

  // One frame: a single-cycle vblank high, then 7 low cycles.
  task automatic frame();
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
    step(7);
  endtask

  logic [13:0] outs;
  int hi0, rise0, dirty;

  initial begin
    reset      = 1'b1;
    vblank     = 1'b0;
    joystick_0 = 16'h0100;
    joystick_1 = 16'h0000;
    ps2_key    = {1'b1, 1'b1, 1'b0, 8'h16};
`ifdef SB_AUTOFIRE_EN
    autofire   = 1'b0;
`endif
    step(4);
    chk("rst_outs", {p1_ctrl, p2_ctrl, start1, start2, coin, test}, 14'h0);

    // Leaving reset with toggle high and coin held: nothing may fire.
    reset = 1'b0;
    hi0 = coin_hi;
    dirty = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      outs = {p1_ctrl, p2_ctrl, start1, start2, coin, test};
      if (outs != 0) dirty++;
    end
    chk("rst_quiet", dirty, 0);
    chk("rst_coin_hi", coin_hi - hi0, 0);

    // Release coin, press again: joystick coin pulses one cycle after edge.
    joystick_0 = 16'h0000;
    step(2);
    rise0 = coin_rise;
    joystick_0[8] = 1'b1;
    step(1);
    chk("joy_coin_lat", coin, 1);
    hi0 = coin_hi;
    frame();
    joystick_0[8] = 1'b0;
    step(2);
    joystick_0[8] = 1'b1;
    step(2);
    frame();
    chk("retrig_hold", coin, 1);
    frame();
    chk("retrig_end", coin, 0);
    frame();
    chk("retrig_lock", coin, 0);
    chk("retrig_len", coin_hi - hi0, 21);
    chk("retrig_rises", coin_rise - rise0, 1);
    joystick_0 = 16'h0000;
    step(2);

    // Keyboard P1 up: two-cycle latency, extended only.
    key(1'b1, 1'b1, 8'h75);
    step(1);
    chk("p1_up_lat1", p1_ctrl, 6'h00);
    step(1);
    chk("p1_up_lat2", p1_ctrl, 6'h08);
    key(1'b0, 1'b1, 8'h75);
    step(2);
    chk("p1_up_rel", p1_ctrl, 6'h00);
    key(1'b1, 1'b0, 8'h75);
    step(3);
    chk("p1_noext", {p1_ctrl, p2_ctrl}, 12'h0);
    key(1'b1, 1'b0, 8'h2D);
    step(2);
    chk("p2_up_key", {p1_ctrl, p2_ctrl}, 12'h008);
    key(1'b0, 1'b0, 8'h2D);
    step(2);

    // Joystick paths: one-cycle latency, player 2 from joystick_1.
    joystick_1[4] = 1'b1;
    step(1);
    chk("p2_fire_joy", p2_ctrl, 6'h10);
    chk("p1_clear", p1_ctrl, 6'h00);
    joystick_1 = 16'h0000;
    joystick_0[0] = 1'b1;
    step(1);
    chk("p1_right_joy", {p1_ctrl, p2_ctrl}, 12'h040);
    joystick_0 = 16'h0040;
    step(1);
    chk("start1_joy", {start1, start2, p1_ctrl}, 8'h80);
    joystick_0 = 16'h0000;
    step(1);

    // Shared start button: last event wins.
    key(1'b1, 1'b0, 8'h16);
    step(2);
    chk("start1_a", start1, 1);
    key(1'b0, 1'b0, 8'h05);
    step(2);
    chk("start1_b_rel", start1, 0);
    key(1'b1, 1'b0, 8'h06);
    step(2);
    chk("start2_b", {start1, start2}, 2'b01);
    key(1'b0, 1'b0, 8'h06);
    step(1);
    key(1'b1, 1'b0, 8'h2C);
    step(2);
    chk("test_key", {test, start2}, 2'b10);
    key(1'b0, 1'b0, 8'h2C);
    step(2);

    // Key coin A held through 5 frames.
    rise0 = coin_rise;
    key(1'b1, 1'b0, 8'h2E);
    step(1);
    chk("coin_lat1", coin, 0);
    step(1);
    chk("coin_lat2", coin, 1);
    hi0 = coin_hi;
    frame();
    chk("coin_f1", coin, 1);
    frame();
    chk("coin_f2", coin, 1);
    frame();
    chk("coin_f3", coin, 0);
    frame();
    frame();
    chk("coin_f5", coin, 0);
    chk("coin_len", coin_hi - hi0, 17);
    chk("coin_rises", coin_rise - rise0, 1);
    key(1'b0, 1'b0, 8'h2E);
    step(2);
    key(1'b1, 1'b0, 8'h36);
    step(2);
    chk("coinb_repulse", coin, 1);
    key(1'b0, 1'b0, 8'h36);
    step(1);
    frame();
    frame();
    frame();
    chk("coinb_done", coin, 0);
    chk("coinb_rises", coin_rise - rise0, 2);

`ifdef SB_AUTOFIRE_EN
    autofire = 1'b1;
    joystick_0[4] = 1'b1;
    step(1);
    chk("af_f0", p1_ctrl[4], 1);
    for (int f = 1; f < 6; f++) begin
      frame();
      chk($sformatf("af_f%0d", f), p1_ctrl[4], (f % 2 == 0) ? 1 : 0);
    end
    joystick_0[4] = 1'b0;
    step(1);
    chk("af_rel", p1_ctrl[4], 0);
    autofire = 1'b0;
    joystick_0[4] = 1'b1;
    step(1);
    frame();
    chk("af_off_pass", p1_ctrl[4], 1);
    joystick_0[4] = 1'b0;
    step(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
